reg_wb_queue: RTL and testbench

Write-side front end for the register file. Accepts writeback requests from the ALU and load paths over valid/ready handshakes and buffers them in a small in-order FIFO. Drains one request per cycle onto the register file write port (regWrite / writeReg / writeData). Reports pending-write hazards for the two decode read ports, so decode stalls until a pending write has retired.

---
 rtl/wb_pkg.sv | 15 +
 rtl/wb_match.sv | 40 ++++
 rtl/reg_wb_queue.sv | 175 +++++++++++++++++
 tb/tb_reg_wb_queue.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared default widths and the queue entry type for the register
// file writeback front end (reg_wb_queue and its wb_match helper).
package wb_pkg;

  localparam int WB_DATA_W = 32;  // register data width
  localparam int WB_ADDR_W = 5;   // register index width (32 registers)
  localparam int WB_DEPTH  = 4;   // FIFO entries, power of two, >= 2

  // One pending register file write.
  typedef struct packed {
    logic [WB_ADDR_W-1:0] dst;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_match.sv
// wb_match: compares one decode read index against every pending write.
// Candidates are supplied in age order, index 0 oldest. Register 0 never hits.
// With WB_FORWARD_EN defined it also returns the data of the youngest hit.
module wb_match #(
  parameter int N      = 5,
  parameter int ADDR_W = 5
`ifdef WB_FORWARD_EN
  ,
  parameter int DATA_W = 32
`endif
) (
  input  logic [ADDR_W-1:0]         idx_i,
  input  logic [N-1:0]              vld_i,
  input  logic [N-1:0][ADDR_W-1:0]  reg_i,
`ifdef WB_FORWARD_EN
  input  logic [N-1:0][DATA_W-1:0]  data_i,
  output logic [DATA_W-1:0]         data_o,
`endif
  output logic                      hit_o
);

  // Scan oldest to youngest so the last hit seen is the youngest one.
  always_comb begin
    hit_o  = 1'b0;
`ifdef WB_FORWARD_EN
    data_o = '0;
`endif
    if (idx_i != '0) begin
      for (int k = 0; k < N; k++) begin
        if (vld_i[k] && (reg_i[k] == idx_i)) begin
          hit_o  = 1'b1;
`ifdef WB_FORWARD_EN
          data_o = data_i[k];
`endif
        end
      end
    end
  end

endmodule

// File: rtl/reg_wb_queue.sv
// reg_wb_queue: in-order writeback queue in front of the register file.
// ALU and load requests are accepted over valid/ready, buffered in a small
// FIFO and drained one per cycle onto the registered write port.
// Decode read-port hazards cover queued entries and the uncommitted output.
// Optional build macro: WB_FORWARD_EN adds fwd1_data/fwd2_data forwarding.
module reg_wb_queue
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DEPTH  = WB_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  output logic              regWrite,
  output logic [ADDR_W-1:0] writeReg,
  output logic [DATA_W-1:0] writeData,
  input  logic [ADDR_W-1:0] rd_reg1,
  input  logic [ADDR_W-1:0] rd_reg2,
  output logic              hazard1,
  output logic              hazard2,
  output logic [ADDR_W-1:0] count
`ifdef WB_FORWARD_EN
  ,
  output logic [DATA_W-1:0] fwd1_data,
  output logic [DATA_W-1:0] fwd2_data
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int NCAND = DEPTH + 1;  // output register plus every FIFO slot

  typedef struct packed {
    logic [ADDR_W-1:0] dst;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            mem_q [DEPTH];
  entry_t            head_entry;
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d, alu_slot;
  logic [CNT_W-1:0]  count_q, count_d, free_slots;
  logic              push_mem, push_alu, pop;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_reg_q, wr_reg_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic [NCAND-1:0]             cand_vld;
  logic [NCAND-1:0][ADDR_W-1:0] cand_reg;
`ifdef WB_FORWARD_EN
  logic [NCAND-1:0][DATA_W-1:0] cand_data;
`endif

  // Ready depends on occupancy only; the last free slot is kept for loads.
  assign free_slots = CNT_W'(DEPTH) - count_q;
  assign mem_ready  = (free_slots != '0);
  assign alu_ready  = (free_slots >= CNT_W'(2));

  // Writes to r0 handshake but are dropped without taking a slot.
  assign push_mem   = mem_valid && mem_ready && (mem_reg != '0);
  assign push_alu   = alu_valid && alu_ready && (alu_reg != '0);
  assign pop        = (count_q != '0);
  assign alu_slot   = push_mem ? tail_q + PTR_W'(1) : tail_q;
  assign head_entry = mem_q[head_q];

  // Next-state for pointers, occupancy and the registered write port.
  always_comb begin
    // NOTE: every always_comb output is given a default first so no latch is inferred.
    head_d    = head_q;
    wr_en_d   = 1'b0;
    wr_reg_d  = wr_reg_q;
    wr_data_d = wr_data_q;
    tail_d    = tail_q + PTR_W'(push_mem) + PTR_W'(push_alu);
    count_d   = count_q + CNT_W'(push_mem) + CNT_W'(push_alu) - CNT_W'(pop);
    if (pop) begin
      head_d    = head_q + PTR_W'(1);
      wr_en_d   = 1'b1;
      wr_reg_d  = head_entry.dst;
      wr_data_d = head_entry.data;
    end
  end

  // Control state and write port; reset drops the queue and the pending write.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      wr_reg_q  <= wr_reg_d;
      wr_data_q <= wr_data_d;
    end
  end

  // FIFO storage: the load entry goes in first, the ALU entry right behind it.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; occupancy alone decides which slots are meaningful.
    if (push_mem) mem_q[tail_q]   <= '{dst: mem_reg, data: mem_data};
    if (push_alu) mem_q[alu_slot] <= '{dst: alu_reg, data: alu_data};
  end

  // Present pending writes in age order: output register first, then head..tail.
  always_comb begin
    cand_vld[0] = wr_en_q;
    cand_reg[0] = wr_reg_q;
`ifdef WB_FORWARD_EN
    cand_data[0] = wr_data_q;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      cand_vld[k+1] = (CNT_W'(k) < count_q);
      cand_reg[k+1] = mem_q[head_q + PTR_W'(k)].dst;
`ifdef WB_FORWARD_EN
      cand_data[k+1] = mem_q[head_q + PTR_W'(k)].data;
`endif
    end
  end

  wb_match #(
    .N      (NCAND),
    .ADDR_W (ADDR_W)
`ifdef WB_FORWARD_EN
    ,
    .DATA_W (DATA_W)
`endif
  ) u_match1 (
    .idx_i  (rd_reg1),
    .vld_i  (cand_vld),
    .reg_i  (cand_reg),
`ifdef WB_FORWARD_EN
    .data_i (cand_data),
    .data_o (fwd1_data),
`endif
    .hit_o  (hazard1)
  );

  wb_match #(
    .N      (NCAND),
    .ADDR_W (ADDR_W)
`ifdef WB_FORWARD_EN
    ,
    .DATA_W (DATA_W)
`endif
  ) u_match2 (
    .idx_i  (rd_reg2),
    .vld_i  (cand_vld),
    .reg_i  (cand_reg),
`ifdef WB_FORWARD_EN
    .data_i (cand_data),
    .data_o (fwd2_data),
`endif
    .hit_o  (hazard2)
  );

  assign regWrite  = wr_en_q;
  assign writeReg  = wr_reg_q;
  assign writeData = wr_data_q;
  assign count     = ADDR_W'(count_q);

endmodule

// File: tb/tb_reg_wb_queue.sv
// tb_reg_wb_queue: directed vector table, hand-written reset and forwarding
// sequences, then randomized traffic against a queue-based reference model.
module tb_reg_wb_queue;
  import wb_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;
  localparam int NVEC   = 18;
  localparam int NRAND  = 1500;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              alu_valid, alu_ready, mem_valid, mem_ready;
  logic [ADDR_W-1:0] alu_reg, mem_reg, writeReg, rd_reg1, rd_reg2, count;
  logic [DATA_W-1:0] alu_data, mem_data, writeData;
  logic              regWrite, hazard1, hazard2;
`ifdef WB_FORWARD_EN
  logic [DATA_W-1:0] fwd1_data, fwd2_data;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  reg_wb_queue #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_reg   (alu_reg),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_reg   (mem_reg),
    .mem_data  (mem_data),
    .regWrite  (regWrite),
    .writeReg  (writeReg),
    .writeData (writeData),
    .rd_reg1   (rd_reg1),
    .rd_reg2   (rd_reg2),
    .hazard1   (hazard1),
    .hazard2   (hazard2),
    .count     (count)
`ifdef WB_FORWARD_EN
    ,
    .fwd1_data (fwd1_data),
    .fwd2_data (fwd2_data)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: pending writes as a plain queue plus the write port.
  wb_entry_t         q[$];
  logic              m_we;
  logic [ADDR_W-1:0] m_reg;
  logic [DATA_W-1:0] m_data;

  function automatic logic model_hz(input logic [ADDR_W-1:0] rd);
    if (rd == '0) return 1'b0;
    if (m_we && m_reg == rd) return 1'b1;
    foreach (q[i]) if (q[i].dst == rd) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [DATA_W-1:0] model_fwd(input logic [ADDR_W-1:0] rd);
    for (int i = q.size() - 1; i >= 0; i--) if (q[i].dst == rd) return q[i].data;
    if (m_we && m_reg == rd) return m_data;
    return '0;
  endfunction

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
    mem_valid = 1'b0; mem_reg = '0; mem_data = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    q.delete();
    m_we = 1'b0; m_reg = '0; m_data = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic              av;
    logic [ADDR_W-1:0] ar;
    logic [DATA_W-1:0] ad;
    logic              mv;
    logic [ADDR_W-1:0] mr;
    logic [DATA_W-1:0] md;
    logic [ADDR_W-1:0] r1;
    logic [ADDR_W-1:0] r2;
    logic              e_ardy;
    logic              e_mrdy;
    logic              e_hz1;
    logic              e_hz2;
    logic              e_we;
    logic [ADDR_W-1:0] e_reg;
    logic [DATA_W-1:0] e_data;
    logic [ADDR_W-1:0] e_cnt;
  } vec_t;

  vec_t vecs [NVEC];

  initial begin
    //          av ar  ad      mv mr  md      r1 r2 ardy mrdy hz1 hz2 we reg data    cnt
    vecs[0]  = '{1, 3, 'h11,   0, 0,  0,      3, 0, 1, 1, 0, 0, 0, 0, 'h0,   1};
    vecs[1]  = '{0, 0, 0,      0, 0,  0,      3, 0, 1, 1, 1, 0, 1, 3, 'h11,  0};
    vecs[2]  = '{0, 0, 0,      0, 0,  0,      3, 0, 1, 1, 1, 0, 0, 3, 'h11,  0};
    vecs[3]  = '{0, 0, 0,      0, 0,  0,      3, 0, 1, 1, 0, 0, 0, 3, 'h11,  0};
    vecs[4]  = '{1, 6, 'hBB,   1, 5,  'hAA,   5, 6, 1, 1, 0, 0, 0, 3, 'h11,  2};
    vecs[5]  = '{0, 0, 0,      0, 0,  0,      5, 6, 1, 1, 1, 1, 1, 5, 'hAA,  1};
    vecs[6]  = '{0, 0, 0,      0, 0,  0,      5, 6, 1, 1, 1, 1, 1, 6, 'hBB,  0};
    vecs[7]  = '{0, 0, 0,      0, 0,  0,      5, 6, 1, 1, 0, 1, 0, 6, 'hBB,  0};
    vecs[8]  = '{1, 0, 'hFF,   0, 0,  0,      0, 0, 1, 1, 0, 0, 0, 6, 'hBB,  0};
    vecs[9]  = '{0, 0, 0,      0, 0,  0,      0, 6, 1, 1, 0, 0, 0, 6, 'hBB,  0};
    vecs[10] = '{1, 2, 'h102,  1, 1,  'h101,  1, 2, 1, 1, 0, 0, 0, 6, 'hBB,  2};
    vecs[11] = '{1, 4, 'h104,  1, 3,  'h103,  1, 2, 1, 1, 1, 1, 1, 1, 'h101, 3};
    vecs[12] = '{1, 6, 'h106,  1, 5,  'h105,  1, 4, 0, 1, 1, 1, 1, 2, 'h102, 3};
    vecs[13] = '{1, 6, 'h106,  1, 7,  'h107,  1, 7, 0, 1, 0, 0, 1, 3, 'h103, 3};
    vecs[14] = '{0, 0, 0,      0, 0,  0,      7, 2, 0, 1, 1, 0, 1, 4, 'h104, 2};
    vecs[15] = '{0, 0, 0,      0, 0,  0,      7, 4, 1, 1, 1, 1, 1, 5, 'h105, 1};
    vecs[16] = '{0, 0, 0,      0, 0,  0,      7, 5, 1, 1, 1, 1, 1, 7, 'h107, 0};
    vecs[17] = '{0, 0, 0,      0, 0,  0,      7, 5, 1, 1, 1, 0, 0, 7, 'h107, 0};

    // Reset state, checked while reset is held.
    rst_n = 1'b0;
    idle_inputs();
    rd_reg1 = 5'd0;
    rd_reg2 = 5'd0;
    q.delete();
    m_we = 1'b0; m_reg = '0; m_data = '0;
    #2;
    check("reset count", count, 0);
    check("reset regWrite", regWrite, 0);
    check("reset writeReg", writeReg, 0);
    check("reset writeData", writeData, 0);
    check("reset alu_ready", alu_ready, 1);
    check("reset mem_ready", mem_ready, 1);
    check("reset hazard1", hazard1, 0);
    check("reset hazard2", hazard2, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table, one cycle per record.
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      alu_valid = vecs[i].av; alu_reg = vecs[i].ar; alu_data = vecs[i].ad;
      mem_valid = vecs[i].mv; mem_reg = vecs[i].mr; mem_data = vecs[i].md;
      rd_reg1   = vecs[i].r1; rd_reg2 = vecs[i].r2;
      #1;
      check($sformatf("v%0d alu_ready", i), alu_ready, vecs[i].e_ardy);
      check($sformatf("v%0d mem_ready", i), mem_ready, vecs[i].e_mrdy);
      check($sformatf("v%0d hazard1", i), hazard1, vecs[i].e_hz1);
      check($sformatf("v%0d hazard2", i), hazard2, vecs[i].e_hz2);
      @(posedge clk);
      #1;
      check($sformatf("v%0d regWrite", i), regWrite, vecs[i].e_we);
      check($sformatf("v%0d writeReg", i), writeReg, vecs[i].e_reg);
      check($sformatf("v%0d writeData", i), writeData, vecs[i].e_data);
      check($sformatf("v%0d count", i), count, vecs[i].e_cnt);
    end

    // Reset with three entries queued: everything drops at once.
    @(negedge clk);
    mem_valid = 1'b1; mem_reg = 5'd1; mem_data = 32'hA1;
    alu_valid = 1'b1; alu_reg = 5'd2; alu_data = 32'hA2;
    @(negedge clk);
    mem_reg = 5'd3; mem_data = 32'hA3;
    alu_reg = 5'd4; alu_data = 32'hA4;
    @(negedge clk);
    idle_inputs();
    #1;
    check("pre-reset count", count, 3);
    check("pre-reset regWrite", regWrite, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async reset count", count, 0);
    check("async reset regWrite", regWrite, 0);
    check("async reset writeReg", writeReg, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("post-reset regWrite c%0d", i), regWrite, 0);
      check($sformatf("post-reset count c%0d", i), count, 0);
    end

`ifdef WB_FORWARD_EN
    // Two writes to r7 in one cycle: the ALU one is younger and must win.
    @(negedge clk);
    mem_valid = 1'b1; mem_reg = 5'd7; mem_data = 32'h0000_0001;
    alu_valid = 1'b1; alu_reg = 5'd7; alu_data = 32'h0000_0002;
    rd_reg1 = 5'd7; rd_reg2 = 5'd7;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle_inputs();
      #1;
      check($sformatf("fwd hazard1 c%0d", i), hazard1, 1);
      check($sformatf("fwd1_data c%0d", i), fwd1_data, 32'h0000_0002);
      check($sformatf("fwd2_data c%0d", i), fwd2_data, 32'h0000_0002);
    end
`endif

    // Randomized traffic against the reference model.
    apply_reset();
    for (int i = 0; i < NRAND; i++) begin
      logic e_ardy, e_mrdy, fire_m, fire_a;
      wb_entry_t e;
      @(negedge clk);
      alu_valid = ($urandom_range(0, 3) != 0);
      alu_reg   = ADDR_W'($urandom_range(0, 7));
      alu_data  = $urandom;
      mem_valid = ($urandom_range(0, 3) != 0);
      mem_reg   = ADDR_W'($urandom_range(0, 7));
      mem_data  = $urandom;
      rd_reg1   = ADDR_W'($urandom_range(0, 7));
      rd_reg2   = ADDR_W'($urandom_range(0, 7));
      #1;
      e_mrdy = (q.size() < DEPTH);
      e_ardy = ((DEPTH - q.size()) >= 2);
      check("rand alu_ready", alu_ready, e_ardy);
      check("rand mem_ready", mem_ready, e_mrdy);
      check("rand count", count, q.size());
      check("rand hazard1", hazard1, model_hz(rd_reg1));
      check("rand hazard2", hazard2, model_hz(rd_reg2));
`ifdef WB_FORWARD_EN
      if (model_hz(rd_reg1)) check("rand fwd1_data", fwd1_data, model_fwd(rd_reg1));
      if (model_hz(rd_reg2)) check("rand fwd2_data", fwd2_data, model_fwd(rd_reg2));
`endif
      fire_m = mem_valid && e_mrdy && (mem_reg != '0);
      fire_a = alu_valid && e_ardy && (alu_reg != '0);
      @(posedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        m_we = 1'b1; m_reg = e.dst; m_data = e.data;
      end else begin
        m_we = 1'b0;
      end
      if (fire_m) begin e.dst = mem_reg; e.data = mem_data; q.push_back(e); end
      if (fire_a) begin e.dst = alu_reg; e.data = alu_data; q.push_back(e); end
      #1;
      check("rand regWrite", regWrite, m_we);
      check("rand writeReg", writeReg, m_reg);
      check("rand writeData", writeData, m_data);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
